// File: rtl/abm_multi_reader.sv
// abm_multi_reader: read-only AXI4 slave that fronts NRAM RAM banks sharing one
// read address and returns the bitwise OR of the bank words on each R beat.
// Optional build macro ABM_BANK_MASK_EN adds input bank_enable[NRAM-1:0] so that
// only enabled banks contribute to the OR.
//
// Handshake semantics: a transfer happens on a rising clock edge where both VALID
// and READY are high. VALID never waits for READY, and once RVALID is high it stays
// high with RDATA/RLAST/RID stable until the beat is taken. ARREADY and RVALID are
// registered; RREADY only gates the FIFO pop and the issue credit.
module abm_multi_reader #(
  parameter int DW          = 512,
  parameter int DD          = 16384,
  parameter int NRAM        = 2,
  parameter int RAM_LATENCY = 1,
  parameter int IDW         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [$clog2(DD)-1:0]      ram_addr,
  input  logic [NRAM*DW-1:0]         ram_data,
`ifdef ABM_BANK_MASK_EN
  input  logic [NRAM-1:0]            bank_enable,
`endif
  input  logic [$clog2(DD*DW/8)-1:0] S_AXI_ARADDR,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  input  logic [IDW-1:0]             S_AXI_ARID,
  input  logic [7:0]                 S_AXI_ARLEN,
  input  logic [1:0]                 S_AXI_ARBURST,
  input  logic [2:0]                 S_AXI_ARSIZE,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARLOCK,
  input  logic [3:0]                 S_AXI_ARCACHE,
  input  logic [3:0]                 S_AXI_ARQOS,
  output logic [DW-1:0]              S_AXI_RDATA,
  output logic [IDW-1:0]             S_AXI_RID,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RLAST,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  input  logic [$clog2(DD*DW/8)-1:0] S_AXI_AWADDR,
  input  logic                       S_AXI_AWVALID,
  input  logic [IDW-1:0]             S_AXI_AWID,
  input  logic [7:0]                 S_AXI_AWLEN,
  input  logic [1:0]                 S_AXI_AWBURST,
  input  logic [DW-1:0]              S_AXI_WDATA,
  input  logic [DW/8-1:0]            S_AXI_WSTRB,
  input  logic                       S_AXI_WLAST,
  input  logic                       S_AXI_WVALID,
  input  logic                       S_AXI_BREADY,
  output logic                       S_AXI_AWREADY,
  output logic                       S_AXI_WREADY,
  output logic                       S_AXI_BVALID,
  output logic [1:0]                 S_AXI_BRESP,
  output logic [1:0]                 dbg_state_o
);

  localparam int AW    = $clog2(DD);
  localparam int BW    = $clog2(DW/8);
  localparam int DEPTH = RAM_LATENCY + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                arready_q, arready_d;
  logic                issue;

  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       ram_addr_q;
  logic [7:0]          len_q;
  logic [1:0]          burst_q;
  logic [IDW-1:0]      id_q;
  logic [7:0]          issue_cnt_q;

  // Tag pipe is one stage longer than the RAM latency: a tag pushed on the edge that
  // drives ram_addr reaches the end exactly when the matching word is valid.
  logic [RAM_LATENCY:0] vld_q;
  logic [RAM_LATENCY:0] last_q;

  logic [DW-1:0]       mem_q [DEPTH];
  logic                last_mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q;
  // Tags in flight plus FIFO entries; bounds what may be issued.
  logic [CW-1:0]       occ_q;

  logic                ar_hs, pop, last_pop, credit, last_issue, tag_exit;
  logic [DW-1:0]       comb_data;

  assign ar_hs      = S_AXI_ARVALID & arready_q;
  assign S_AXI_RVALID = (cnt_q != '0);
  assign pop        = S_AXI_RVALID & S_AXI_RREADY;
  assign last_pop   = pop & last_mem_q[rd_ptr_q];
  // An entry popped on this edge frees its slot on the same edge.
  assign credit     = (occ_q < CW'(DEPTH)) | pop;
  assign last_issue = issue & (issue_cnt_q == len_q);
  assign tag_exit   = vld_q[RAM_LATENCY];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // State register and registered ARREADY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_hs)      state_d = ST_ISSUE;
      ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (last_pop)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Outputs of the FSM: ARREADY next value and the per-clock issue strobe.
  always_comb begin
    arready_d = 1'b0;
    issue     = 1'b0;
    case (state_q)
      ST_IDLE:  arready_d = ~ar_hs;
      ST_ISSUE: issue     = credit;
      ST_DRAIN: arready_d = last_pop;
      default:  arready_d = 1'b0;
    endcase
  end

  // Address sequencing: FIXED holds, WRAP stays in an aligned window, else increment.
  always_comb begin
    logic [AW-1:0] incr;
    logic [AW-1:0] mask;
    logic          wrap_ok;
    incr    = addr_q + AW'(1);
    mask    = AW'(len_q[3:0]);
    wrap_ok = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    case (burst_q)
      2'd0:    addr_d = addr_q;
      2'd2:    addr_d = wrap_ok ? ((addr_q & ~mask) | (incr & mask)) : incr;
      default: addr_d = incr;
    endcase
  end

  // Burst capture, RAM address issue and tag pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      ram_addr_q  <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      id_q        <= '0;
      issue_cnt_q <= '0;
      vld_q       <= '0;
      last_q      <= '0;
    end else begin
      if (ar_hs) begin
        addr_q      <= S_AXI_ARADDR[BW +: AW];
        len_q       <= S_AXI_ARLEN;
        burst_q     <= S_AXI_ARBURST;
        id_q        <= S_AXI_ARID;
        issue_cnt_q <= '0;
      end else if (issue) begin
        ram_addr_q  <= addr_q;
        addr_q      <= addr_d;
        issue_cnt_q <= issue_cnt_q + 8'd1;
      end
      vld_q  <= {vld_q[RAM_LATENCY-1:0], issue};
      last_q <= {last_q[RAM_LATENCY-1:0], last_issue};
    end
  end

  // OR of the participating banks for the word leaving the tag pipe.
  always_comb begin
    comb_data = '0;
    for (int k = 0; k < NRAM; k++) begin
`ifdef ABM_BANK_MASK_EN
      if (bank_enable[k])
`endif
        comb_data = comb_data | ram_data[k*DW +: DW];
    end
  end

  // FIFO pointers, fill count and credit occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      if (tag_exit) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(tag_exit) - CW'(pop);
      occ_q <= occ_q + CW'(issue) - CW'(pop);
    end
  end

  // FIFO storage; contents are meaningless while the count is zero.
  always_ff @(posedge clk) begin
    if (tag_exit) begin
      mem_q[wr_ptr_q]      <= comb_data;
      last_mem_q[wr_ptr_q] <= last_q[RAM_LATENCY];
    end
  end

  assign ram_addr      = ram_addr_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = mem_q[rd_ptr_q];
  assign S_AXI_RLAST   = S_AXI_RVALID & last_mem_q[rd_ptr_q];
  assign S_AXI_RID     = id_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_AWREADY = 1'b0;
  assign S_AXI_WREADY  = 1'b0;
  assign S_AXI_BVALID  = 1'b0;
  assign S_AXI_BRESP   = 2'b00;
  assign dbg_state_o   = state_q;

  // Inputs with no function in a read-only slave.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_ARADDR[BW-1:0], S_AXI_ARSIZE, S_AXI_ARPROT, S_AXI_ARLOCK,
                           S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_AWADDR, S_AXI_AWVALID,
                           S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_WDATA,
                           S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_BREADY};

endmodule

// File: tb/tb_abm_multi_reader.sv
// Testbench for abm_multi_reader: instance A uses the default geometry
// (RAM_LATENCY=1), instance B uses RAM_LATENCY=3 with a narrow bus for stall tests.
`timescale 1ns/1ps
module tb_abm_multi_reader;

  localparam int DW    = 512;
  localparam int DD    = 16384;
  localparam int AW    = 14;
  localparam int ADW   = 20;
  localparam int BYTES = 64;
  localparam int IDW   = 4;
  localparam int DWB   = 32;
  localparam int DDB   = 64;
  localparam int AWB   = 6;
  localparam int ADWB  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic [AW-1:0]    ram_addr_a, ram_q_a;
  logic [2*DW-1:0]  ram_data_a;
  logic [ADW-1:0]   araddr;
  logic             arvalid, arready, rlast, rvalid, rready;
  logic [IDW-1:0]   arid, rid;
  logic [7:0]       arlen;
  logic [1:0]       arburst, rresp, dbg_a, bresp_a;
  logic [DW-1:0]    rdata;
  logic             awready_a, wready_a, bvalid_a;
`ifdef ABM_BANK_MASK_EN
  logic [1:0]       bank_en;
`endif

  // Instance B signals
  logic [AWB-1:0]   ram_addr_b, b1, b2, b3;
  logic [2*DWB-1:0] ram_data_b;
  logic [ADWB-1:0]  araddr_b;
  logic             arvalid_b, arready_b, rlast_b, rvalid_b, rready_b;
  logic [IDW-1:0]   arid_b, rid_b;
  logic [7:0]       arlen_b;
  logic [1:0]       arburst_b, rresp_b, dbg_b, bresp_b;
  logic [DWB-1:0]   rdata_b;
  logic             awready_b, wready_b, bvalid_b;

  logic [DW-1:0]    exp_q[$];
  logic [DWB-1:0]   expb_q[$];

  // Bank contents: word 5 holds 0x0F / 0xF0, other words carry the address in bits 29:16.
  function automatic logic [31:0] bank_word(input int k, input int a);
    if (a == 5) return (k == 0) ? 32'h0F : 32'hF0;
    return (32'(a) << 16) | ((k == 0) ? 32'h0A : 32'h50);
  endfunction

  // Hand-derived OR of both banks at word a.
  function automatic logic [31:0] exp_word(input int a);
    if (a == 5) return 32'hFF;
    return (32'(a) << 16) | 32'h5A;
  endfunction

  // RAM models: latency 1 for A, latency 3 for B.
  always @(posedge clk) begin
    ram_q_a <= ram_addr_a;
    b1 <= ram_addr_b;
    b2 <= b1;
    b3 <= b2;
  end
  assign ram_data_a = {DW'(bank_word(1, int'(ram_q_a))), DW'(bank_word(0, int'(ram_q_a)))};
  assign ram_data_b = {bank_word(1, int'(b3)), bank_word(0, int'(b3))};

  abm_multi_reader #(.DW(DW), .DD(DD), .NRAM(2), .RAM_LATENCY(1), .IDW(IDW)) u_dut_a (
    .clk(clk), .reset(reset), .ram_addr(ram_addr_a), .ram_data(ram_data_a),
`ifdef ABM_BANK_MASK_EN
    .bank_enable(bank_en),
`endif
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen), .S_AXI_ARBURST(arburst),
    .S_AXI_ARSIZE(3'd6), .S_AXI_ARPROT(3'd0), .S_AXI_ARLOCK(1'b0),
    .S_AXI_ARCACHE(4'd0), .S_AXI_ARQOS(4'd0),
    .S_AXI_RDATA(rdata), .S_AXI_RID(rid), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .S_AXI_AWADDR('0), .S_AXI_AWVALID(1'b0), .S_AXI_AWID('0), .S_AXI_AWLEN(8'd0),
    .S_AXI_AWBURST(2'd0), .S_AXI_WDATA('0), .S_AXI_WSTRB('0), .S_AXI_WLAST(1'b0),
    .S_AXI_WVALID(1'b0), .S_AXI_BREADY(1'b0),
    .S_AXI_AWREADY(awready_a), .S_AXI_WREADY(wready_a), .S_AXI_BVALID(bvalid_a),
    .S_AXI_BRESP(bresp_a), .dbg_state_o(dbg_a)
  );

  abm_multi_reader #(.DW(DWB), .DD(DDB), .NRAM(2), .RAM_LATENCY(3), .IDW(IDW)) u_dut_b (
    .clk(clk), .reset(reset), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
`ifdef ABM_BANK_MASK_EN
    .bank_enable(2'b11),
`endif
    .S_AXI_ARADDR(araddr_b), .S_AXI_ARVALID(arvalid_b), .S_AXI_ARREADY(arready_b),
    .S_AXI_ARID(arid_b), .S_AXI_ARLEN(arlen_b), .S_AXI_ARBURST(arburst_b),
    .S_AXI_ARSIZE(3'd2), .S_AXI_ARPROT(3'd0), .S_AXI_ARLOCK(1'b0),
    .S_AXI_ARCACHE(4'd0), .S_AXI_ARQOS(4'd0),
    .S_AXI_RDATA(rdata_b), .S_AXI_RID(rid_b), .S_AXI_RRESP(rresp_b), .S_AXI_RLAST(rlast_b),
    .S_AXI_RVALID(rvalid_b), .S_AXI_RREADY(rready_b),
    .S_AXI_AWADDR('0), .S_AXI_AWVALID(1'b0), .S_AXI_AWID('0), .S_AXI_AWLEN(8'd0),
    .S_AXI_AWBURST(2'd0), .S_AXI_WDATA('0), .S_AXI_WSTRB('0), .S_AXI_WLAST(1'b0),
    .S_AXI_WVALID(1'b0), .S_AXI_BREADY(1'b0),
    .S_AXI_AWREADY(awready_b), .S_AXI_WREADY(wready_b), .S_AXI_BVALID(bvalid_b),
    .S_AXI_BRESP(bresp_b), .dbg_state_o(dbg_b)
  );

  // Driver: present AR on A, wait for the handshake, then count clocks to first RVALID.
  // Returns at the negedge where RVALID was first seen (lat = -1 if never).
  task automatic ar_send(input int word, input int len, input int burst, input int id,
                         output int lat);
    int ok;
    ok  = 0;
    lat = -1;
    @(negedge clk);
    araddr  = ADW'(word * BYTES);
    arlen   = 8'(len);
    arburst = 2'(burst);
    arid    = IDW'(id);
    arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (arready) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL ar_handshake word=%0d: arready never seen (actual 0, required 1)", word);
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rvalid) begin lat = k; break; end
    end
  endtask

  // Scoreboard drain: RREADY high, pop exp_q per beat, check data/RLAST/RID/RRESP and
  // that beats arrive back-to-back, then that the slave is idle and ready again.
  task automatic collect(input string name, input logic [IDW-1:0] id);
    int n, got, gaps;
    logic [DW-1:0] e;
    logic exp_last;
    n = exp_q.size();
    got = 0;
    gaps = 0;
    rready = 1'b1;
    for (int c = 0; c < n + 40 && got < n; c++) begin
      if (c > 0) @(negedge clk);
      if (rvalid) begin
        e = exp_q.pop_front();
        exp_last = (got == n - 1);
        checks++;
        if (rdata !== e) begin
          errors++;
          $display("FAIL %s_rdata beat %0d: actual %0h required %0h", name, got, rdata[63:0], e[63:0]);
        end
        checks++;
        if (rlast !== exp_last) begin
          errors++;
          $display("FAIL %s_rlast beat %0d: actual %b required %b", name, got, rlast, exp_last);
        end
        checks++;
        if (rid !== id || rresp !== 2'b00) begin
          errors++;
          $display("FAIL %s_rid beat %0d: actual id %0h resp %0d required id %0h resp 0",
                   name, got, rid, rresp, id);
        end
        got++;
      end else if (got > 0) begin
        gaps++;
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_count: actual %0d beats required %0d", name, got, n);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL %s_back_to_back: actual %0d idle cycles required 0", name, gaps);
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0 || dbg_a !== 2'd0) begin
      errors++;
      $display("FAIL %s_idle_after: actual arready %b rvalid %b state %0d required 1 0 0",
               name, arready, rvalid, dbg_a);
    end
  endtask

  task automatic check_lat(input string name, input int lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL %s_latency: actual %0d clocks required 3", name, lat);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || ram_addr_a !== '0 ||
        dbg_a !== 2'd0 || arready_b !== 1'b0 || rvalid_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: actual arready %b rvalid %b rlast %b ram_addr %0d state %0d required 0 0 0 0 0",
               arready, rvalid, rlast, ram_addr_a, dbg_a);
    end
    checks++;
    if (awready_a !== 1'b0 || wready_a !== 1'b0 || bvalid_a !== 1'b0 || bresp_a !== 2'd0 ||
        awready_b !== 1'b0 || wready_b !== 1'b0 || bvalid_b !== 1'b0 || bresp_b !== 2'd0) begin
      errors++;
      $display("FAIL write_channel_tie: actual awready %b wready %b bvalid %b required 0 0 0",
               awready_a, wready_a, bvalid_a);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || arready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_arready: actual %b/%b required 1/1", arready, arready_b);
    end
  endtask

  task automatic test_single_beat;
    int lat;
    exp_q.push_back(DW'(exp_word(5)));
    rready = 1'b1;
    ar_send(5, 0, 1, 3, lat);
    check_lat("single", lat);
    collect("single", 4'd3);
  endtask

  task automatic test_incr_wrap_dd;
    int lat;
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'(exp_word((DD - 2 + i) % DD)));
    ar_send(DD - 2, 15, 1, 7, lat);
    check_lat("incr16", lat);
    collect("incr16", 4'd7);
  endtask

  task automatic test_wrap;
    int lat;
    exp_q.push_back(DW'(exp_word(6)));
    exp_q.push_back(DW'(exp_word(7)));
    exp_q.push_back(DW'(exp_word(4)));
    exp_q.push_back(DW'(exp_word(5)));
    ar_send(6, 3, 2, 1, lat);
    check_lat("wrap4", lat);
    collect("wrap4", 4'd1);
    // WRAP with a non power-of-two length behaves as INCR
    exp_q.push_back(DW'(exp_word(6)));
    exp_q.push_back(DW'(exp_word(7)));
    exp_q.push_back(DW'(exp_word(8)));
    ar_send(6, 2, 2, 2, lat);
    check_lat("wrap_bad_len", lat);
    collect("wrap_bad_len", 4'd2);
  endtask

  task automatic test_fixed_and_burst3;
    int lat;
    repeat (3) exp_q.push_back(DW'(exp_word(9)));
    ar_send(9, 2, 0, 4, lat);
    check_lat("fixed", lat);
    collect("fixed", 4'd4);
    exp_q.push_back(DW'(exp_word(20)));
    exp_q.push_back(DW'(exp_word(21)));
    ar_send(20, 1, 3, 15, lat);
    check_lat("burst3", lat);
    collect("burst3", 4'd15);
  endtask

  task automatic test_reset_mid_burst;
    int lat;
    rready = 1'b0;
    ar_send(40, 7, 1, 2, lat);
    check_lat("pre_reset", lat);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: actual rvalid %b rlast %b arready %b required 0 0 0",
               rvalid, rlast, arready);
    end
    @(negedge clk);
    reset = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: actual arready %b rvalid %b required 1 0", arready, rvalid);
    end
    exp_q.push_back(DW'(exp_word(5)));
    ar_send(5, 0, 1, 9, lat);
    check_lat("after_reset", lat);
    collect("after_reset", 4'd9);
  endtask

`ifdef ABM_BANK_MASK_EN
  task automatic test_bank_mask;
    int lat;
    bank_en = 2'b10;
    exp_q.push_back(DW'(32'hF0));
    ar_send(5, 0, 1, 6, lat);
    check_lat("mask", lat);
    collect("mask", 4'd6);
    bank_en = 2'b11;
  endtask
`endif

  // Instance B: 32-beat INCR from word 10 with RREADY high one clock in three.
  task automatic test_stall_latency3;
    int ok, got, max_out, outst, first_v;
    logic [DWB-1:0] e;
    ok = 0; got = 0; max_out = 0; first_v = -1;
    for (int i = 0; i < 32; i++) expb_q.push_back(exp_word(10 + i));
    @(negedge clk);
    araddr_b = ADWB'(10 * 4); arlen_b = 8'd31; arburst_b = 2'd1; arid_b = 4'd5;
    arvalid_b = 1'b1; rready_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arready_b) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL stall_handshake: actual arready 0 required 1");
    end
    @(negedge clk);
    arvalid_b = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 32; cyc++) begin
      rready_b = (cyc % 3 == 0);
      outst = int'(ram_addr_b) - 10 + 1 - got;
      if (outst > max_out) max_out = outst;
      if (rvalid_b && first_v < 0) first_v = cyc;
      if (rvalid_b && rready_b) begin
        e = expb_q.pop_front();
        checks++;
        if (rdata_b !== e || rlast_b !== (got == 31) || rid_b !== 4'd5) begin
          errors++;
          $display("FAIL stall_beat %0d: actual data %0h last %b id %0h required %0h %b 5",
                   got, rdata_b, rlast_b, rid_b, e, (got == 31));
        end
        got++;
      end
      @(negedge clk);
    end
    rready_b = 1'b0;
    checks++;
    if (got != 32) begin
      errors++;
      $display("FAIL stall_count: actual %0d beats required 32", got);
    end
    checks++;
    if (first_v != 5) begin
      errors++;
      $display("FAIL stall_latency: actual %0d clocks required 5", first_v);
    end
    checks++;
    if (max_out != 5) begin
      errors++;
      $display("FAIL stall_credit: actual max outstanding %0d required 5", max_out);
    end
    checks++;
    if (ram_addr_b !== AWB'(41) || arready_b !== 1'b1 || rvalid_b !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: actual ram_addr %0d arready %b rvalid %b required 41 1 0",
               ram_addr_b, arready_b, rvalid_b);
    end
    expb_q.delete();
  endtask

  initial begin
    araddr = '0; arvalid = 1'b0; arid = '0; arlen = '0; arburst = '0; rready = 1'b0;
    araddr_b = '0; arvalid_b = 1'b0; arid_b = '0; arlen_b = '0; arburst_b = '0; rready_b = 1'b0;
`ifdef ABM_BANK_MASK_EN
    bank_en = 2'b11;
`endif
    test_reset();
    test_single_beat();
    test_incr_wrap_dd();
    test_wrap();
    test_fixed_and_burst3();
    test_stall_latency3();
    test_reset_mid_burst();
`ifdef ABM_BANK_MASK_EN
    test_bank_mask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
